// File: rtl/iir6_coeff_bank.sv
// -----------------------------------------------------------------------------
// iir6_coeff_bank
// Coefficient bank and update sequencer for the sixth-order 27-bit IIR filter.
// A host fills a shadow bank one word at a time, then commits it. The whole
// shadow bank is copied into the active outputs in a single state_clk edge,
// on the first falling edge of lr_clk (frame boundary) after the commit. The
// filter therefore never sees a mix of old and new coefficients.
//
// Ports:
//   state_clk       system clock
//   reset           synchronous active-high reset
//   lr_clk          audio frame clock, asynchronous to state_clk
//   wr_en/wr_addr/wr_data   shadow write port (0..6 b1..b7, 7..12 a2..a7,
//                   13 scale, 14..15 illegal)
//   wr_ready        write/commit accepted when high
//   wr_err          one-cycle pulse on an illegal or rejected write
//   commit          request a shadow->active swap at the next frame boundary
//   commit_pending  commit accepted, swap not yet done
//   commit_ack      one-cycle pulse on the edge the active bank updates
//   rd_addr/rd_shadow/rd_data   registered readback of either bank
//   b1..b7, a2..a7  active coefficients, 3.24 two's complement
//   scale           active output shift
// -----------------------------------------------------------------------------
module iir6_coeff_bank (
  input  logic        state_clk,
  input  logic        reset,
  input  logic        lr_clk,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [26:0] wr_data,
  output logic        wr_ready,
  output logic        wr_err,
  input  logic        commit,
  output logic        commit_pending,
  output logic        commit_ack,
  input  logic [3:0]  rd_addr,
  input  logic        rd_shadow,
  output logic [26:0] rd_data,
  output logic [26:0] b1,
  output logic [26:0] b2,
  output logic [26:0] b3,
  output logic [26:0] b4,
  output logic [26:0] b5,
  output logic [26:0] b6,
  output logic [26:0] b7,
  output logic [26:0] a2,
  output logic [26:0] a3,
  output logic [26:0] a4,
  output logic [26:0] a5,
  output logic [26:0] a6,
  output logic [26:0] a7,
  output logic [2:0]  scale
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  localparam logic [3:0]  ADDR_SCALE = 4'd13;
  localparam logic [26:0] UNITY      = 27'h1000000;
  // Index 0 is b1; every other coefficient is zero -> unity passthrough.
  localparam logic [12:0][26:0] PASS_COEF = {{12{27'd0}}, UNITY};

  // Readback mux over one bank; scale is zero-extended, illegal reads give 0.
  function automatic logic [26:0] bank_read(input logic [12:0][26:0] coef,
                                            input logic [2:0]        scl,
                                            input logic [3:0]        addr);
    logic [26:0] r;
    r = 27'd0;
    if (addr < ADDR_SCALE) begin
      r = coef[addr];
    end else if (addr == ADDR_SCALE) begin
      r = {24'd0, scl};
    end else begin
      r = 27'd0;
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [2:0]         lr_pipe_q, lr_pipe_d;  // [0],[1] synchronizer, [2] history
  logic [12:0][26:0]  shadow_q, shadow_d;
  logic [2:0]         sh_scale_q, sh_scale_d;
  logic [12:0][26:0]  active_q, active_d;
  logic [2:0]         act_scale_q, act_scale_d;
  logic               wr_ready_q, wr_ready_d;
  logic               wr_err_q, wr_err_d;
  logic               commit_pending_q, commit_pending_d;
  logic               commit_ack_q, commit_ack_d;
  logic [26:0]        rd_data_q, rd_data_d;

  logic fb_s;
  logic wr_accept_s;
  logic swap_s;

  // Next-state logic: synchronizer, shadow writes, commit FSM, swap, readback.
  always_comb begin
    lr_pipe_d   = {lr_pipe_q[1:0], lr_clk};
    fb_s        = lr_pipe_q[2] & ~lr_pipe_q[1];

    // wr_ready_q is low while pending and for one cycle after a swap.
    wr_accept_s = wr_en & wr_ready_q & (wr_addr <= ADDR_SCALE);
    wr_err_d    = wr_en & ~wr_accept_s;

    shadow_d    = shadow_q;
    sh_scale_d  = sh_scale_q;
    if (wr_accept_s) begin
      if (wr_addr == ADDR_SCALE) begin
        sh_scale_d = wr_data[2:0];
      end else begin
        shadow_d[wr_addr] = wr_data;
      end
    end else begin
      shadow_d   = shadow_q;
    end

    swap_s  = 1'b0;
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // fb is deliberately ignored here: a commit landing on an fb waits
        // for the following one.
        if (commit) begin
          state_d = ST_PEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (fb_s) begin
          swap_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The shadow bank already holds any write accepted with the commit.
    if (swap_s) begin
      active_d    = shadow_q;
      act_scale_d = sh_scale_q;
    end else begin
      active_d    = active_q;
      act_scale_d = act_scale_q;
    end

    // Ready only once IDLE has been registered for a full cycle.
    wr_ready_d       = (state_q == ST_IDLE) & (state_d == ST_IDLE);
    commit_pending_d = (state_d == ST_PEND);
    commit_ack_d     = swap_s;

    if (rd_shadow) begin
      rd_data_d = bank_read(shadow_q, sh_scale_q, rd_addr);
    end else begin
      rd_data_d = bank_read(active_q, act_scale_q, rd_addr);
    end
  end

  // State registers with synchronous reset to the passthrough set.
  always_ff @(posedge state_clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      lr_pipe_q        <= 3'b000;
      shadow_q         <= PASS_COEF;
      sh_scale_q       <= 3'd0;
      active_q         <= PASS_COEF;
      act_scale_q      <= 3'd0;
      wr_ready_q       <= 1'b1;
      wr_err_q         <= 1'b0;
      commit_pending_q <= 1'b0;
      commit_ack_q     <= 1'b0;
      rd_data_q        <= 27'd0;
    end else begin
      state_q          <= state_d;
      lr_pipe_q        <= lr_pipe_d;
      shadow_q         <= shadow_d;
      sh_scale_q       <= sh_scale_d;
      active_q         <= active_d;
      act_scale_q      <= act_scale_d;
      wr_ready_q       <= wr_ready_d;
      wr_err_q         <= wr_err_d;
      commit_pending_q <= commit_pending_d;
      commit_ack_q     <= commit_ack_d;
      rd_data_q        <= rd_data_d;
    end
  end

  assign wr_ready       = wr_ready_q;
  assign wr_err         = wr_err_q;
  assign commit_pending = commit_pending_q;
  assign commit_ack     = commit_ack_q;
  assign rd_data        = rd_data_q;

  assign b1    = active_q[0];
  assign b2    = active_q[1];
  assign b3    = active_q[2];
  assign b4    = active_q[3];
  assign b5    = active_q[4];
  assign b6    = active_q[5];
  assign b7    = active_q[6];
  assign a2    = active_q[7];
  assign a3    = active_q[8];
  assign a4    = active_q[9];
  assign a5    = active_q[10];
  assign a6    = active_q[11];
  assign a7    = active_q[12];
  assign scale = act_scale_q;

endmodule

// File: tb/tb_iir6_coeff_bank.sv
// Directed bench for iir6_coeff_bank. Inputs change and outputs are sampled
// on the falling edge of state_clk.
module tb_iir6_coeff_bank;

  logic        state_clk = 1'b0;
  logic        reset = 1'b1;
  logic        lr_clk = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [26:0] wr_data = 27'd0;
  logic        wr_ready, wr_err;
  logic        commit = 1'b0;
  logic        commit_pending, commit_ack;
  logic [3:0]  rd_addr = 4'd0;
  logic        rd_shadow = 1'b0;
  logic [26:0] rd_data;
  logic [26:0] b1, b2, b3, b4, b5, b6, b7, a2, a3, a4, a5, a6, a7;
  logic [2:0]  scale;

  int checks = 0;
  int failures = 0;

  iir6_coeff_bank dut (
    .state_clk(state_clk), .reset(reset), .lr_clk(lr_clk),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_err(wr_err), .commit(commit),
    .commit_pending(commit_pending), .commit_ack(commit_ack),
    .rd_addr(rd_addr), .rd_shadow(rd_shadow), .rd_data(rd_data),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7),
    .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .scale(scale)
  );

  always #5 state_clk = ~state_clk;

  task automatic chk(input string tag, input logic [26:0] obs, input logic [26:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return at the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge state_clk);
      @(negedge state_clk);
    end
  endtask

  // Check that no commit_ack appears for n cycles.
  task automatic no_ack(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step(1);
      chk(tag, {26'd0, commit_ack}, 27'd0);
    end
  endtask

  initial begin
    // ---------------- Reset ----------------
    @(negedge state_clk);
    step(2);
    reset = 1'b0;
    chk("rst_b1", b1, 27'h1000000);
    chk("rst_b2", b2, 27'd0);
    chk("rst_b7", b7, 27'd0);
    chk("rst_a2", a2, 27'd0);
    chk("rst_a7", a7, 27'd0);
    chk("rst_scale", {24'd0, scale}, 27'd0);
    chk("rst_wr_ready", {26'd0, wr_ready}, 27'd1);
    chk("rst_pending", {26'd0, commit_pending}, 27'd0);
    chk("rst_ack", {26'd0, commit_ack}, 27'd0);
    chk("rst_wr_err", {26'd0, wr_err}, 27'd0);
    chk("rst_rd_data", rd_data, 27'd0);
    rd_addr = 4'd0; rd_shadow = 1'b1; step(1);
    chk("rst_rd_sh_b1", rd_data, 27'h1000000);
    rd_shadow = 1'b0; step(1);
    chk("rst_rd_act_b1", rd_data, 27'h1000000);
    rd_addr = 4'd13; rd_shadow = 1'b1; step(1);
    chk("rst_rd_sh_scale", rd_data, 27'd0);

    // Bring the synchronized lr_clk high.
    lr_clk = 1'b1; step(4);

    // ---------------- Write then commit ----------------
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 27'h0800000; step(1);
    wr_addr = 4'd13; wr_data = 27'h7FFFFFA; step(1);  // scale keeps [2:0] = 2
    wr_en = 1'b0;
    rd_addr = 4'd1; rd_shadow = 1'b1; step(1);
    chk("wr_rd_sh_b2", rd_data, 27'h0800000);
    rd_addr = 4'd13; step(1);
    chk("wr_rd_sh_scale", rd_data, 27'd2);
    chk("wr_act_b2_before", b2, 27'd0);
    commit = 1'b1; step(1); commit = 1'b0;
    chk("cm_pending", {26'd0, commit_pending}, 27'd1);
    chk("cm_wr_ready", {26'd0, wr_ready}, 27'd0);
    step(2);
    chk("cm_still_pending", {26'd0, commit_pending}, 27'd1);
    chk("cm_b2_held", b2, 27'd0);
    lr_clk = 1'b0;
    step(1);
    chk("sw_e1_b2", b2, 27'd0);
    chk("sw_e1_ack", {26'd0, commit_ack}, 27'd0);
    step(1);
    chk("sw_e2_b2", b2, 27'd0);
    chk("sw_e2_scale", {24'd0, scale}, 27'd0);
    chk("sw_e2_ack", {26'd0, commit_ack}, 27'd0);
    step(1);
    chk("sw_e3_b2", b2, 27'h0800000);
    chk("sw_e3_scale", {24'd0, scale}, 27'd2);
    chk("sw_e3_ack", {26'd0, commit_ack}, 27'd1);
    chk("sw_e3_pending", {26'd0, commit_pending}, 27'd0);
    chk("sw_e3_wr_ready", {26'd0, wr_ready}, 27'd0);
    chk("sw_e3_b1", b1, 27'h1000000);
    step(1);
    chk("sw_e4_ack", {26'd0, commit_ack}, 27'd0);
    chk("sw_e4_wr_ready", {26'd0, wr_ready}, 27'd1);
    chk("sw_e4_b2", b2, 27'h0800000);

    // ---------------- Rejected write while pending ----------------
    lr_clk = 1'b1; step(4);
    commit = 1'b1; step(1); commit = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 27'h7FFFFFF; step(1);
    wr_en = 1'b0;
    chk("rej_wr_err", {26'd0, wr_err}, 27'd1);
    rd_addr = 4'd8; rd_shadow = 1'b1; step(1);
    chk("rej_wr_err_end", {26'd0, wr_err}, 27'd0);
    chk("rej_rd_sh_a3", rd_data, 27'd0);
    lr_clk = 1'b0; step(3);
    chk("rej_ack", {26'd0, commit_ack}, 27'd1);
    chk("rej_act_a3", a3, 27'd0);
    step(1);

    // ---------------- Illegal address ----------------
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 27'h123; step(1);
    wr_en = 1'b0;
    chk("ill_wr_err", {26'd0, wr_err}, 27'd1);
    rd_addr = 4'd14; rd_shadow = 1'b1; step(1);
    chk("ill_wr_err_end", {26'd0, wr_err}, 27'd0);
    chk("ill_rd_sh", rd_data, 27'd0);
    rd_addr = 4'd15; rd_shadow = 1'b0; step(1);
    chk("ill_rd_act15", rd_data, 27'd0);
    rd_addr = 4'd1; rd_shadow = 1'b1; step(1);
    chk("ill_rd_sh_b2", rd_data, 27'h0800000);
    chk("ill_b2", b2, 27'h0800000);
    chk("ill_scale", {24'd0, scale}, 27'd2);

    // ---------------- Write and commit in the same cycle ----------------
    lr_clk = 1'b1; step(4);
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 27'h0000001; commit = 1'b1; step(1);
    wr_en = 1'b0; commit = 1'b0;
    chk("same_pending", {26'd0, commit_pending}, 27'd1);
    chk("same_wr_err", {26'd0, wr_err}, 27'd0);
    lr_clk = 1'b0; step(3);
    chk("same_ack", {26'd0, commit_ack}, 27'd1);
    chk("same_b7", b7, 27'h0000001);

    // ---------------- Commit landing in the fb cycle ----------------
    lr_clk = 1'b1; step(4);
    lr_clk = 1'b0; step(2);        // fb is now active for the next edge
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 27'h0000ABC; commit = 1'b1; step(1);
    wr_en = 1'b0; commit = 1'b0;
    chk("fbc_pending", {26'd0, commit_pending}, 27'd1);
    chk("fbc_ack", {26'd0, commit_ack}, 27'd0);
    no_ack("fbc_wait_ack", 4);
    chk("fbc_b3_held", b3, 27'd0);
    lr_clk = 1'b1;
    no_ack("fbc_rise_ack", 4);
    lr_clk = 1'b0; step(2);
    chk("fbc_e2_ack", {26'd0, commit_ack}, 27'd0);
    step(1);
    chk("fbc_swap_ack", {26'd0, commit_ack}, 27'd1);
    chk("fbc_b3", b3, 27'h0000ABC);

    // ---------------- Reset while pending ----------------
    lr_clk = 1'b1; step(4);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 27'h0000005; step(1);
    wr_en = 1'b0;
    commit = 1'b1; step(1); commit = 1'b0;
    chk("rp_pending", {26'd0, commit_pending}, 27'd1);
    reset = 1'b1;
    no_ack("rp_in_reset_ack", 2);
    reset = 1'b0;
    chk("rp_pending_clr", {26'd0, commit_pending}, 27'd0);
    chk("rp_wr_ready", {26'd0, wr_ready}, 27'd1);
    chk("rp_b1", b1, 27'h1000000);
    chk("rp_b2", b2, 27'd0);
    chk("rp_b3", b3, 27'd0);
    chk("rp_b7", b7, 27'd0);
    chk("rp_scale", {24'd0, scale}, 27'd0);
    rd_addr = 4'd3; rd_shadow = 1'b1; step(1);
    chk("rp_rd_sh_b4", rd_data, 27'd0);
    no_ack("rp_sync_ack", 3);
    lr_clk = 1'b0;
    no_ack("rp_fb_ack", 5);
    chk("rp_b1_after_fb", b1, 27'h1000000);
    chk("rp_b4_after_fb", b4, 27'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iir6_coeff_bank.md
# iir6_coeff_bank

Coefficient bank and update sequencer for the sixth-order 27-bit IIR filter. It holds the active b1..b7, a2..a7 and scale values driven into the filter, plus a shadow copy that a host writes one word at a time. A committed shadow set is copied to the active outputs in one cycle at the next falling edge of lr_clk. The filter's MAC pass starts on the lr_clk rising edge, so the filter never sees a mixed set of old and new coefficients.

## Interface
Parameters: none. Coefficient width is fixed at 27 bits, 3.24 two's complement.

- state_clk  in  1  system clock; the filter's state-machine clock
- reset  in  1  synchronous, active-high reset, sampled on state_clk rising edge
- lr_clk  in  1  audio frame clock; asynchronous to state_clk
- wr_en  in  1  shadow write strobe
- wr_addr  in  4  0..6 = b1..b7, 7..12 = a2..a7, 13 = scale, 14..15 illegal
- wr_data  in  27  write data; for address 13 only [2:0] is used
- wr_ready  out  1  high when a write or commit is accepted (low while a commit is pending)
- wr_err  out  1  one-cycle pulse on an illegal address or a rejected write
- commit  in  1  request to swap shadow to active at the next frame boundary
- commit_pending  out  1  commit accepted, swap not yet done
- commit_ack  out  1  one-cycle pulse in the cycle the active registers update
- rd_addr  in  4  readback address, same map as wr_addr
- rd_shadow  in  1  1 = read the shadow bank, 0 = read the active bank
- rd_data  out  27  registered readback; scale is zero-extended; illegal addresses return 0
- b1..b7, a2..a7  out  27 each  active coefficients, registered
- scale  out  3  active output shift, registered

## Operation
- Reset values, active and shadow banks: b1 = 27'h1000000 (1.0), all other coefficients 0, scale 0. This is a unity passthrough.
- Reset values of the other outputs: wr_ready 1, wr_err 0, commit_pending 0, commit_ack 0, rd_data 0.
- lr_clk passes through a 2-flop synchronizer plus a history flop. A frame boundary (fb) is a 1 to 0 transition of the synchronized value.
- The synchronizer and history flops reset to 0, so no fb can occur in the first 3 cycles after reset.
- Writes: when wr_en is high, wr_ready is high and wr_addr ≤ 13, the shadow[wr_addr] register loads wr_data on the clock edge.
- wr_en with wr_addr ≥ 14 pulses wr_err; the shadow bank is unchanged.
- wr_en while commit_pending is high is rejected: wr_err pulses and the shadow bank is unchanged.
- Commit: a commit pulse while commit_pending is low sets commit_pending.
  - A commit pulse while commit_pending is high is ignored; no error is raised.
- Two states:
  - IDLE: wr_ready = 1. commit goes to PEND.
  - PEND: wr_ready = 0, commit_pending = 1. On fb, the whole shadow bank is copied into the active outputs in the same edge, commit_ack pulses, and the state returns to IDLE.
- A write and a commit in the same cycle, in IDLE: the write lands in the shadow bank first, then PEND is entered. The committed set includes that write.
- A commit in the same cycle as an fb: the swap waits for the next fb. At least one full lr_clk period of stable PEND is guaranteed.
- No arithmetic is performed. Values are stored bit-exact; scale stores wr_data[2:0].
- Reset in PEND: commit_pending is cleared, no commit_ack pulses, and both banks return to passthrough.

## Timing
- Write latency 1 cycle: shadow and shadow readback reflect the write on the next edge.
- Readback latency 1 cycle: rd_data is registered from the rd_addr and rd_shadow sampled on the previous edge.
- Swap latency from a falling lr_clk pin edge: 3 state_clk edges (2 synchronizer + 1 edge detect). Active outputs and commit_ack change together on the third edge.
- commit_ack is exactly 1 cycle wide.
- commit_pending falls on the same edge that commit_ack rises.
- wr_ready rises on the edge after the swap, IDLE being registered.
- Between swaps, the active outputs are constant: there is no glitch and no partial update.

## Test plan
- Reset: assert reset 2 cycles -> b1 = 27'h1000000, b2..b7 = 0, a2..a7 = 0, scale = 0, wr_ready = 1, commit_pending = 0. Check readback from both banks.
- Write then commit: write b2 = 27'h0800000 and scale = 3'd2, then commit, then drop lr_clk from 1 to 0. Required:
  - active outputs unchanged until the 3rd state_clk edge after the lr_clk fall;
  - then b2 = 27'h0800000 and scale = 2;
  - commit_ack high for 1 cycle.
- Rejected write while pending: commit, then write a3 = 27'h7FFFFFF before the fb. Required:
  - wr_err pulses;
  - shadow readback of a3 is still 0;
  - after the swap, the active a3 is 0.
- Illegal address: wr_addr = 14, wr_data = 27'h123 -> wr_err pulses 1 cycle; rd_addr = 14 returns 0; no register changes.
- Same-cycle cases: write b7 = 27'h0000001 together with commit -> after the swap, b7 = 1. A commit landing in the fb cycle -> no swap until the following fb.
- Reset mid-pending: commit, then reset before the fb -> commit_pending = 0, no commit_ack, coefficients back to passthrough; a subsequent fb produces no swap.
